// File: rtl/mat_row_argmax.sv
// Purpose: per-row argmax over an M x P float32 matrix, one column scanned per cycle, all rows in parallel.
// Latency: output_stb rises P-1 edges after the accepting edge (on the accepting edge when P = 1).
// Backpressure: results hold in OUT until output_ack; input_mat_ack stays low until then.
module mat_row_argmax #(
    parameter int M     = 2,
    parameter int P     = 2,
    parameter int IDX_W = (P > 1) ? $clog2(P) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [M-1:0][P-1:0][31:0]   input_mat,
    input  logic                        input_mat_stb,
    output logic                        input_mat_ack,
    output logic [M-1:0][IDX_W-1:0]     output_idx,
    output logic [M-1:0][31:0]          output_max,
    output logic                        output_stb,
    input  logic                        output_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                         r_state;
    logic [M-1:0][P-1:0][31:0]      r_mat;
    logic [IDX_W-1:0]               r_cnt;
    logic [M-1:0][IDX_W-1:0]        r_idx;
    logic [M-1:0][31:0]             r_max;
    logic                           r_in_ack;
    logic                           r_out_stb;

    logic [M-1:0][31:0]             w_col;
    logic [M-1:0]                   w_better;

    // NaN: all-ones exponent with a nonzero mantissa.
    function automatic logic f_is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    // Maps a non-NaN float onto an unsigned key with the same ordering (-0 below +0).
    function automatic logic [31:0] f_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Strictly-better test: a NaN candidate loses to any number; ties keep the earlier column.
    function automatic logic f_better(input logic [31:0] nv, input logic [31:0] cand);
        logic nv_nan;
        logic cand_nan;
        nv_nan   = f_is_nan(nv);
        cand_nan = f_is_nan(cand);
        return (cand_nan && !nv_nan) ||
               (!cand_nan && !nv_nan && (f_key(nv) > f_key(cand)));
    endfunction

    // Select the column under scan from the latched matrix, one element per row.
    always_comb begin
        w_col = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < P; j++) begin
                if (r_cnt == IDX_W'(j)) begin
                    w_col[i] = r_mat[i][j];
                end
            end
        end
    end

    // Per-row comparison of the scanned column against the running candidate.
    always_comb begin
        w_better = '0;
        for (int i = 0; i < M; i++) begin
            w_better[i] = f_better(w_col[i], r_max[i]);
        end
    end

    // Control FSM with registered handshake outputs and per-row candidate registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_mat     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_max     <= '0;
            r_in_ack  <= 1'b0;
            r_out_stb <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_in_ack) begin
                        r_in_ack <= 1'b1;
                    end else if (input_mat_stb) begin
                        r_mat    <= input_mat;
                        r_in_ack <= 1'b0;
                        r_idx    <= '0;
                        for (int i = 0; i < M; i++) begin
                            r_max[i] <= input_mat[i][0];
                        end
                        if (P == 1) begin
                            r_cnt     <= '0;
                            r_out_stb <= 1'b1;
                            r_state   <= OUT;
                        end else begin
                            r_cnt   <= IDX_W'(1);
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    for (int i = 0; i < M; i++) begin
                        if (w_better[i]) begin
                            r_idx[i] <= r_cnt;
                            r_max[i] <= w_col[i];
                        end
                    end
                    if (r_cnt == IDX_W'(P - 1)) begin
                        r_cnt     <= '0;
                        r_out_stb <= 1'b1;
                        r_state   <= OUT;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (output_ack) begin
                        r_out_stb <= 1'b0;
                        r_in_ack  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_in_ack  <= 1'b0;
                    r_out_stb <= 1'b0;
                end
            endcase
        end
    end

    assign input_mat_ack = r_in_ack;
    assign output_stb    = r_out_stb;
    assign output_idx    = r_idx;
    assign output_max    = r_max;

endmodule

// File: doc/mat_row_argmax.md
Name: mat_row_argmax

Overview:
- Downstream consumer of mat_product. Accepts one M x P IEEE-754 single-precision matrix (row-major, the layout mat_product produces) over a stb/ack handshake.
- Finds the maximum element of each row and its column index by scanning one column per cycle, all M rows compared in parallel.
- Presents per-row index and max value over a second stb/ack handshake.
- Used as the classification stage after the final layer's matrix product.

Parameters:
- M, 2, number of rows (rows classified independently).
- P, 2, number of columns (candidates per row); P >= 1.
- IDX_W, (P > 1 ? $clog2(P) : 1), width of each column index.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- input_mat  input  [M-1:0][P-1:0][31:0]  matrix; element [i][j] = row i, column j.
- input_mat_stb  input  1  upstream data valid.
- input_mat_ack  output  1  block ready to accept input_mat.
- output_idx  output  [M-1:0][IDX_W-1:0]  argmax column of each row.
- output_max  output  [M-1:0][31:0]  max value of each row, bit-exact copy of the selected element.
- output_stb  output  1  results valid.
- output_ack  input  1  downstream consumed results.

Behaviour:
- Transfer rule: a handshake completes on a rising edge where stb and ack are both high.
- Reset (rst low, asynchronous):
  - state = IDLE; input_mat_ack = 0, output_stb = 0.
  - output_idx, output_max, column counter and the internal matrix copy = 0.
  - Reset mid-scan or mid-output abandons the matrix; nothing is emitted afterwards.
- FSM IDLE:
  - If input_mat_ack = 0, set it to 1 at the next edge.
  - If input_mat_ack = 1 and input_mat_stb = 1: latch the whole matrix, load column 0 of every row as candidate (idx 0), and drop input_mat_ack to 0.
  - Go to SCAN with counter = 1, or straight to OUT (output_stb <= 1) when P = 1.
- FSM SCAN:
  - Each cycle compare column j against each row's candidate; replace on the "better" rule below; j increments.
  - On the edge that processes j = P-1: go to OUT and set output_stb <= 1.
- FSM OUT:
  - output_stb is high; output_idx and output_max hold stable.
  - On the edge where output_ack = 1: output_stb <= 0, input_mat_ack <= 1, go to IDLE.
- Latency: output_stb rises P-1 edges after the accepting edge (same edge when P = 1).
- Throughput: at most one matrix per P+1 cycles when output_ack is held high.
- input_mat and input_mat_stb changes outside the accepting edge are ignored; the scan uses the latched copy only.
- output_idx and output_max keep their last values after the OUT handshake, until the next scan overwrites them.
- Comparison key (non-NaN): key(x) = x[31] ? ~x : (x | 32'h80000000), compared unsigned. This gives a total order with -0 < +0 and handles infinities naturally.
- NaN: exponent all ones and mantissa nonzero.
- "Better" rule: new replaces candidate iff (candidate is NaN and new is not NaN) or (neither is NaN and key(new) > key(candidate)).
  - Strictly greater, so on a tie the lowest column index wins.
  - An all-NaN row returns idx 0 and column 0's NaN bits.
- Purely comparison/mux logic; no floating-point arithmetic, no rounding.

Test Plan:
- M=2,P=2, mat_product results fed in sequence, each must appear on output_stb:
  - [22,28;49,64] (0x41B00000,0x41E00000;0x42440000,0x42800000) -> idx [1,1], max [0x41E00000,0x42800000].
  - [40,52;19,28] -> idx [1,1], max [0x42500000,0x41E00000].
  - [46,34;34,37] -> idx [0,1], max [0x42380000,0x42140000].
- M=2,P=3, negatives/zeros/ties:
  - Row0 [-1,-2,-0.5] = 0xBF800000,0xC0000000,0xBF000000 -> idx 2, max 0xBF000000.
  - Row1 [-0,+0,-0] = 0x80000000,0x00000000,0x80000000 -> idx 1, max 0x00000000.
  - Then row [3,3,1] -> idx 0 (first of a tie).
- M=1,P=3, NaN/Inf:
  - [0x7FC00000,0x40A00000,0xFF800000] -> idx 1, max 0x40A00000.
  - All-NaN row -> idx 0, max 0x7FC00000.
  - [0x7F800000,0x7FC00000,0x40A00000] -> idx 0.
- Timing and backpressure:
  - P=3: output_stb rises exactly 2 edges after the accepting edge.
  - Hold output_ack low 20 cycles: output_stb, output_idx and output_max stay stable; input_mat_ack stays 0; changing input_mat is not consumed.
  - Release output_ack: next matrix is accepted, result matches the new data.
- P=1 edge case: output_stb rises on the accepting edge itself; idx = 0; max equals the element.
- Reset: assert rst low during SCAN (and separately during OUT):
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, input_mat_ack rises after one edge and a fresh matrix produces a correct result.
